// File: rtl/axi4_stream_frag_arbiter_if.sv
// ---------------------------------------------------------------------------
// axi4_stream_if
//
// Plain AXI4-Stream bundle used for the merged output of
// axi4_stream_frag_arbiter.
//
// Signals: tvalid, tready, tdata[TDATA_WIDTH], tkeep/tstrb[TDATA_WIDTH/8],
//          tlast, tid[TID_WIDTH], tdest[TDEST_WIDTH], tuser[TUSER_WIDTH].
// Modports: master drives everything except tready; slave is the mirror.
// ---------------------------------------------------------------------------
interface axi4_stream_if #(
    parameter int TDATA_WIDTH = 64,
    parameter int TID_WIDTH   = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TUSER_WIDTH = 1
);
    logic                       tvalid;
    logic                       tready;
    logic [TDATA_WIDTH-1:0]     tdata;
    logic [TDATA_WIDTH/8-1:0]   tkeep;
    logic [TDATA_WIDTH/8-1:0]   tstrb;
    logic                       tlast;
    logic [TID_WIDTH-1:0]       tid;
    logic [TDEST_WIDTH-1:0]     tdest;
    logic [TUSER_WIDTH-1:0]     tuser;

    modport master (
        output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser,
        output tready
    );
endinterface

// File: rtl/axi4_stream_frag_arbiter.sv
// ---------------------------------------------------------------------------
// axi4_stream_frag_arbiter
//
// Round-robin arbiter sharing one AXI4-Stream output between SRC_CNT
// fragmented packet sources. The grant only moves after a tlast handshake,
// so fragments are never interleaved. A source may keep the grant for up to
// FRAGS_PER_GRANT consecutive fragments while it stays valid.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   src_tvalid_i/tready_o   per-source handshake
//   src_tdata_i ... tuser_i packed per-source payload, source k in slice k
//   pkt_o                   merged output stream (axi4_stream_if.master)
//   grant_o                 one-hot grant, zero while idle
//   busy_o                  high while a fragment is in progress
//
// Optional build macro: AXI4_STREAM_FRAG_ARBITER_REG_OUT_EN
//   Defined   - two-entry skid buffer registers every pkt_o output; source
//               ready depends only on buffer occupancy; fragment end is
//               taken from the source-side tlast handshake.
//   Undefined - combinational pass-through of the granted source.
// ---------------------------------------------------------------------------
module axi4_stream_frag_arbiter #(
    parameter int SRC_CNT         = 4,
    parameter int TDATA_WIDTH     = 64,
    parameter int TID_WIDTH       = 1,
    parameter int TDEST_WIDTH     = 1,
    parameter int TUSER_WIDTH     = 1,
    parameter int FRAGS_PER_GRANT = 1,
    parameter int SRC_IDX_WIDTH   = (SRC_CNT > 1) ? $clog2(SRC_CNT) : 1
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [SRC_CNT-1:0]                 src_tvalid_i,
    output logic [SRC_CNT-1:0]                 src_tready_o,
    input  logic [SRC_CNT*TDATA_WIDTH-1:0]     src_tdata_i,
    input  logic [SRC_CNT*TDATA_WIDTH/8-1:0]   src_tkeep_i,
    input  logic [SRC_CNT*TDATA_WIDTH/8-1:0]   src_tstrb_i,
    input  logic [SRC_CNT-1:0]                 src_tlast_i,
    input  logic [SRC_CNT*TID_WIDTH-1:0]       src_tid_i,
    input  logic [SRC_CNT*TDEST_WIDTH-1:0]     src_tdest_i,
    input  logic [SRC_CNT*TUSER_WIDTH-1:0]     src_tuser_i,
    axi4_stream_if.master                      pkt_o,
    output logic [SRC_CNT-1:0]                 grant_o,
    output logic                               busy_o
);
    localparam int KW  = TDATA_WIDTH / 8;
    localparam int FCW = $clog2(FRAGS_PER_GRANT + 1);
    // Payload layout, MSB first: tlast, tdata, tkeep, tstrb, tid, tdest, tuser
    localparam int PW  = 1 + TDATA_WIDTH + 2 * KW + TID_WIDTH + TDEST_WIDTH + TUSER_WIDTH;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                     state_reg,     state_next;
    logic [SRC_IDX_WIDTH-1:0]   grant_idx_reg, grant_idx_next;
    logic [SRC_CNT-1:0]         grant_reg,     grant_next;
    logic                       busy_reg,      busy_next;
    logic [SRC_IDX_WIDTH-1:0]   rr_ptr_reg,    rr_ptr_next;
    logic [FCW-1:0]             frag_cnt_reg,  frag_cnt_next;
    logic [SRC_IDX_WIDTH-1:0]   last_idx_reg,  last_idx_next;

    // ------------------------------------------------------------------
    // Per-source payload unpacking
    // ------------------------------------------------------------------
    logic [PW-1:0] src_payload [SRC_CNT];

    genvar gi;
    generate
        for (gi = 0; gi < SRC_CNT; gi++) begin : g_unpack
            assign src_payload[gi] = {
                src_tlast_i[gi],
                src_tdata_i[gi*TDATA_WIDTH +: TDATA_WIDTH],
                src_tkeep_i[gi*KW +: KW],
                src_tstrb_i[gi*KW +: KW],
                src_tid_i[gi*TID_WIDTH +: TID_WIDTH],
                src_tdest_i[gi*TDEST_WIDTH +: TDEST_WIDTH],
                src_tuser_i[gi*TUSER_WIDTH +: TUSER_WIDTH]
            };
        end
    endgenerate

    logic [PW-1:0] mux_payload;
    logic          mux_valid;
    logic          src_ready;   // ready seen by the granted source
    logic          src_hs;      // handshake on the granted source
    logic          frag_end;

    assign mux_payload = src_payload[grant_idx_reg];
    assign mux_valid   = (state_reg == BUSY) && src_tvalid_i[grant_idx_reg];
    assign src_hs      = mux_valid && src_ready;
    assign frag_end    = src_hs && mux_payload[PW-1];

    // grant_reg is zero outside BUSY, so this also forces ready low in IDLE.
    assign src_tready_o = grant_reg & {SRC_CNT{src_ready}};
    assign grant_o      = grant_reg;
    assign busy_o       = busy_reg;

    // ------------------------------------------------------------------
    // Round-robin scan: first valid source starting at rr_ptr, wrapping
    // explicitly so non-power-of-2 source counts never see an index of
    // SRC_CNT.
    // ------------------------------------------------------------------
    logic [SRC_IDX_WIDTH-1:0] rr_pick;

    always_comb begin : rr_scan
        logic                     found;
        logic [SRC_IDX_WIDTH-1:0] cand;
        found   = 1'b0;
        cand    = '0;
        rr_pick = rr_ptr_reg;
        for (int k = 0; k < SRC_CNT; k++) begin
            cand = SRC_IDX_WIDTH'((int'(rr_ptr_reg) + k) % SRC_CNT);
            if (!found && src_tvalid_i[cand]) begin
                found   = 1'b1;
                rr_pick = cand;
            end
        end
    end

    // The previous owner may continue while its quota is not exhausted.
    logic keep_last;
    assign keep_last = (frag_cnt_reg < FCW'(FRAGS_PER_GRANT)) && src_tvalid_i[last_idx_reg];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        grant_idx_next = grant_idx_reg;
        grant_next     = grant_reg;
        busy_next      = busy_reg;
        rr_ptr_next    = rr_ptr_reg;
        frag_cnt_next  = frag_cnt_reg;
        last_idx_next  = last_idx_reg;

        case (state_reg)
            IDLE: begin
                if (|src_tvalid_i) begin
                    state_next = BUSY;
                    busy_next  = 1'b1;
                    if (keep_last) begin
                        grant_idx_next = last_idx_reg;
                    end else begin
                        grant_idx_next = rr_pick;
                        frag_cnt_next  = '0;
                    end
                    grant_next                 = '0;
                    grant_next[grant_idx_next] = 1'b1;
                end
            end
            BUSY: begin
                if (frag_end) begin
                    if (frag_cnt_reg != FCW'(FRAGS_PER_GRANT)) begin
                        frag_cnt_next = frag_cnt_reg + 1'b1;
                    end
                    last_idx_next = grant_idx_reg;
                    rr_ptr_next   = (grant_idx_reg == SRC_IDX_WIDTH'(SRC_CNT - 1)) ?
                                    '0 : grant_idx_reg + 1'b1;
                    grant_next    = '0;
                    busy_next     = 1'b0;
                    state_next    = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg     <= IDLE;
            grant_idx_reg <= '0;
            grant_reg     <= '0;
            busy_reg      <= 1'b0;
            rr_ptr_reg    <= '0;
            frag_cnt_reg  <= '0;
            last_idx_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            grant_idx_reg <= grant_idx_next;
            grant_reg     <= grant_next;
            busy_reg      <= busy_next;
            rr_ptr_reg    <= rr_ptr_next;
            frag_cnt_reg  <= frag_cnt_next;
            last_idx_reg  <= last_idx_next;
        end
    end

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
`ifdef AXI4_STREAM_FRAG_ARBITER_REG_OUT_EN
    // Two-entry skid buffer: out_* is the entry presented on pkt_o, skid_*
    // catches a beat accepted while the output entry is stalled.
    logic [PW-1:0] out_payload_reg;
    logic [PW-1:0] skid_payload_reg;
    logic          out_valid_reg;
    logic          skid_valid_reg;
    logic          out_take;

    assign src_ready = !(out_valid_reg && skid_valid_reg);
    // Output entry may be (re)loaded when empty or being consumed.
    assign out_take  = !out_valid_reg || pkt_o.tready;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else if (out_take) begin
            out_valid_reg  <= skid_valid_reg || src_hs;
            skid_valid_reg <= skid_valid_reg && src_hs;
        end else if (src_hs) begin
            skid_valid_reg <= 1'b1;
        end
    end

    // Payload registers carry no reset; their valid flags qualify them.
    always_ff @(posedge clk_i) begin
        if (out_take) begin
            out_payload_reg <= skid_valid_reg ? skid_payload_reg : mux_payload;
        end
        if (src_hs && (skid_valid_reg || !out_take)) begin
            skid_payload_reg <= mux_payload;
        end
    end

    assign pkt_o.tvalid = out_valid_reg;
    assign {pkt_o.tlast, pkt_o.tdata, pkt_o.tkeep, pkt_o.tstrb,
            pkt_o.tid, pkt_o.tdest, pkt_o.tuser} = out_payload_reg;
`else
    assign src_ready    = pkt_o.tready;
    assign pkt_o.tvalid = mux_valid;
    assign {pkt_o.tlast, pkt_o.tdata, pkt_o.tkeep, pkt_o.tstrb,
            pkt_o.tid, pkt_o.tdest, pkt_o.tuser} = mux_payload;
`endif

endmodule

// File: tb/tb_axi4_stream_frag_arbiter.sv
`timescale 1ns/1ps
module tb_axi4_stream_frag_arbiter;
    localparam int N  = 4;
    localparam int DW = 64;
    localparam int KW = 8;
    localparam int NI = 2;   // instance 0: quota 1, instance 1: quota 2

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]    vld   [NI];
    logic [N-1:0]    dut_rdy [NI];
    logic [N-1:0]    lst   [NI];
    logic [N-1:0]    tid   [NI];
    logic [N-1:0]    tdest [NI];
    logic [N-1:0]    tuser [NI];
    logic [N-1:0]    gnt   [NI];
    logic [N*DW-1:0] dat   [NI];
    logic [N*KW-1:0] keep  [NI];
    logic [N*KW-1:0] strb  [NI];
    logic            busy  [NI];
    logic            o_rdy [NI];
    logic            o_vld [NI];
    logic            o_lst [NI];
    logic [DW-1:0]   o_dat [NI];
    logic [KW-1:0]   o_keep[NI];
    logic [KW-1:0]   o_strb[NI];
    logic [2:0]      o_side[NI];

    axi4_stream_if #(.TDATA_WIDTH(DW), .TID_WIDTH(1), .TDEST_WIDTH(1), .TUSER_WIDTH(1)) pk0 ();
    axi4_stream_if #(.TDATA_WIDTH(DW), .TID_WIDTH(1), .TDEST_WIDTH(1), .TUSER_WIDTH(1)) pk1 ();

    assign pk0.tready = o_rdy[0];
    assign pk1.tready = o_rdy[1];
    assign o_vld[0]  = pk0.tvalid;  assign o_vld[1]  = pk1.tvalid;
    assign o_lst[0]  = pk0.tlast;   assign o_lst[1]  = pk1.tlast;
    assign o_dat[0]  = pk0.tdata;   assign o_dat[1]  = pk1.tdata;
    assign o_keep[0] = pk0.tkeep;   assign o_keep[1] = pk1.tkeep;
    assign o_strb[0] = pk0.tstrb;   assign o_strb[1] = pk1.tstrb;
    assign o_side[0] = {pk0.tid, pk0.tdest, pk0.tuser};
    assign o_side[1] = {pk1.tid, pk1.tdest, pk1.tuser};

    axi4_stream_frag_arbiter #(
        .SRC_CNT(N), .TDATA_WIDTH(DW), .TID_WIDTH(1), .TDEST_WIDTH(1),
        .TUSER_WIDTH(1), .FRAGS_PER_GRANT(1)
    ) dut0 (
        .clk_i(clk), .rst_i(rst),
        .src_tvalid_i(vld[0]), .src_tready_o(dut_rdy[0]),
        .src_tdata_i(dat[0]), .src_tkeep_i(keep[0]), .src_tstrb_i(strb[0]),
        .src_tlast_i(lst[0]), .src_tid_i(tid[0]), .src_tdest_i(tdest[0]),
        .src_tuser_i(tuser[0]), .pkt_o(pk0), .grant_o(gnt[0]), .busy_o(busy[0])
    );

    axi4_stream_frag_arbiter #(
        .SRC_CNT(N), .TDATA_WIDTH(DW), .TID_WIDTH(1), .TDEST_WIDTH(1),
        .TUSER_WIDTH(1), .FRAGS_PER_GRANT(2)
    ) dut1 (
        .clk_i(clk), .rst_i(rst),
        .src_tvalid_i(vld[1]), .src_tready_o(dut_rdy[1]),
        .src_tdata_i(dat[1]), .src_tkeep_i(keep[1]), .src_tstrb_i(strb[1]),
        .src_tlast_i(lst[1]), .src_tid_i(tid[1]), .src_tdest_i(tdest[1]),
        .src_tuser_i(tuser[1]), .pkt_o(pk1), .grant_o(gnt[1]), .busy_o(busy[1])
    );

    // Source behaviour
    bit  on       [NI][N];
    int  frag_no  [NI][N];
    int  beat_no  [NI][N];
    int  flen     [NI][N];
    int  gap      [NI][N];
    bit  stall_req[NI][N];
    int  fixed_len;
    bit  rand_mode;
    bit  rdy_rand;
    logic [31:0] salt;

    // Fragment-level reference: who owns the link, and arbitration history
    bit  m_busy [NI];
    int  m_src  [NI];
    int  m_rr   [NI];
    int  m_last [NI];
    int  m_cnt  [NI];

    int  ord [NI][$];
    int  src_beats [NI];
    int  out_beats [NI];

    int  checks   = 0;
    int  failures = 0;

    function automatic int quota(int i);
        return (i == 0) ? 1 : 2;
    endfunction

    function automatic logic [63:0] bdata(int k, int f, int b);
        return {8'(k), 8'(b), 16'(f), salt ^ 32'(f * 131 + b * 7)};
    endfunction

    function automatic logic [7:0] bkeep(int k, int f, int b, int len);
        if (b == len - 1) return 8'hFF >> ((f + k) % 8);
        return 8'hFF;
    endfunction

    function automatic logic [7:0] bstrb(int k, int f, int b, int len);
        return bkeep(k, f, b, len) & (8'h5A ^ 8'(f));
    endfunction

    function automatic logic [2:0] bside(int k, int f, int b);
        return {f[0], b[0], k[0] ^ f[1]};
    endfunction

    function automatic int onehot_idx(logic [N-1:0] g);
        for (int k = 0; k < N; k++) if (g[k]) return k;
        return 7;
    endfunction

    function automatic int newlen();
        return rand_mode ? int'($urandom_range(1, 5)) : fixed_len;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_on(input logic [N-1:0] mask);
        for (int i = 0; i < NI; i++)
            for (int k = 0; k < N; k++) on[i][k] = mask[k];
    endtask

    task automatic drive();
        for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < N; k++) begin
                vld[i][k]             = on[i][k] && (gap[i][k] == 0);
                dat[i][k*DW +: DW]    = bdata(k, frag_no[i][k], beat_no[i][k]);
                keep[i][k*KW +: KW]   = bkeep(k, frag_no[i][k], beat_no[i][k], flen[i][k]);
                strb[i][k*KW +: KW]   = bstrb(k, frag_no[i][k], beat_no[i][k], flen[i][k]);
                lst[i][k]             = (beat_no[i][k] == flen[i][k] - 1);
                {tid[i][k], tdest[i][k], tuser[i][k]} = bside(k, frag_no[i][k], beat_no[i][k]);
            end
            o_rdy[i] = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    task automatic init_state();
        for (int i = 0; i < NI; i++) begin
            m_busy[i] = 1'b0; m_src[i] = 0; m_rr[i] = 0; m_last[i] = 0; m_cnt[i] = 0;
            ord[i].delete();
            src_beats[i] = 0; out_beats[i] = 0;
            for (int k = 0; k < N; k++) begin
                frag_no[i][k] = 0; beat_no[i][k] = 0; gap[i][k] = 0;
                stall_req[i][k] = 1'b0; flen[i][k] = newlen();
            end
        end
    endtask

    // Compare output state against the reference, then advance sources
    // and reference by one clock.
    task automatic sample_update();
        logic [N-1:0] eg;
        logic [N-1:0] er;
        int s;
        for (int i = 0; i < NI; i++) begin
            s  = m_src[i];
            eg = '0;
            if (m_busy[i]) eg[s] = 1'b1;
            er = o_rdy[i] ? eg : '0;
            chk($sformatf("i%0d_busy", i), 64'(busy[i]), 64'(m_busy[i]));
            chk($sformatf("i%0d_grant", i), 64'(gnt[i]), 64'(eg));
            chk($sformatf("i%0d_src_tready", i), 64'(dut_rdy[i]), 64'(er));
            chk($sformatf("i%0d_tvalid", i), 64'(o_vld[i]), 64'(m_busy[i] && vld[i][s]));
            if (m_busy[i] && vld[i][s]) begin
                chk($sformatf("i%0d_tdata", i), o_dat[i], bdata(s, frag_no[i][s], beat_no[i][s]));
                chk($sformatf("i%0d_tkeep", i), 64'(o_keep[i]),
                    64'(bkeep(s, frag_no[i][s], beat_no[i][s], flen[i][s])));
                chk($sformatf("i%0d_tstrb", i), 64'(o_strb[i]),
                    64'(bstrb(s, frag_no[i][s], beat_no[i][s], flen[i][s])));
                chk($sformatf("i%0d_tlast", i), 64'(o_lst[i]),
                    64'(beat_no[i][s] == flen[i][s] - 1));
                chk($sformatf("i%0d_side", i), 64'(o_side[i]),
                    64'(bside(s, frag_no[i][s], beat_no[i][s])));
            end

            if (o_vld[i] && o_rdy[i]) begin
                out_beats[i]++;
                if (o_lst[i]) ord[i].push_back(onehot_idx(gnt[i]));
            end

            if (m_busy[i]) begin
                if (vld[i][s] && o_rdy[i] && lst[i][s]) begin
                    m_cnt[i]  = (m_cnt[i] < quota(i)) ? m_cnt[i] + 1 : m_cnt[i];
                    m_last[i] = s;
                    m_rr[i]   = (s + 1) % N;
                    m_busy[i] = 1'b0;
                end
            end else if (vld[i] != '0) begin
                if (m_cnt[i] < quota(i) && vld[i][m_last[i]]) begin
                    m_src[i] = m_last[i];
                end else begin
                    m_cnt[i] = 0;
                    for (int j = N - 1; j >= 0; j--)
                        if (vld[i][(m_rr[i] + j) % N]) m_src[i] = (m_rr[i] + j) % N;
                end
                m_busy[i] = 1'b1;
            end

            for (int k = 0; k < N; k++) begin
                if (gap[i][k] > 0) gap[i][k]--;
                if (vld[i][k] && dut_rdy[i][k]) begin
                    src_beats[i]++;
                    if (stall_req[i][k]) begin
                        gap[i][k] = 5;
                        stall_req[i][k] = 1'b0;
                    end else if (rand_mode && $urandom_range(0, 3) == 0) begin
                        gap[i][k] = $urandom_range(1, 3);
                    end
                    if (beat_no[i][k] == flen[i][k] - 1) begin
                        frag_no[i][k]++;
                        beat_no[i][k] = 0;
                        flen[i][k] = newlen();
                    end else begin
                        beat_no[i][k]++;
                    end
                end
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            sample_update();
            @(posedge clk);
            #1;
            drive();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        init_state();
        drive();
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("i%0d_rst_busy", i), 64'(busy[i]), 64'd0);
            chk($sformatf("i%0d_rst_grant", i), 64'(gnt[i]), 64'd0);
            chk($sformatf("i%0d_rst_tvalid", i), 64'(o_vld[i]), 64'd0);
            chk($sformatf("i%0d_rst_src_tready", i), 64'(dut_rdy[i]), 64'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive();
    endtask

    // Expected order is packed as hex digits, first fragment in the top digit.
    task automatic chk_ord(input string ph, input int i, input int n, input int code);
        int e;
        chk($sformatf("%s_i%0d_frag_count", ph, i), 64'(ord[i].size() >= n), 64'd1);
        for (int j = 0; j < n && j < ord[i].size(); j++) begin
            e = (code >> (4 * (n - 1 - j))) & 15;
            chk($sformatf("%s_i%0d_order%0d", ph, i, j), 64'(ord[i][j]), 64'(e));
        end
    endtask

    task automatic chk_balance(input string ph);
        for (int i = 0; i < NI; i++)
            chk($sformatf("%s_i%0d_beats_in_vs_out", ph, i), 64'(out_beats[i]), 64'(src_beats[i]));
    endtask

    initial begin
        salt      = $urandom;
        rst       = 1'b1;
        rand_mode = 1'b0;
        rdy_rand  = 1'b0;
        fixed_len = 3;
        set_on('0);
        init_state();
        drive();
        @(posedge clk);
        #1;

        // All four sources busy, 3-beat fragments
        set_on(4'b1111); fixed_len = 3; rdy_rand = 1'b0;
        do_reset();
        run(22);
        chk_ord("all_valid", 0, 5, 'h01230);
        chk_ord("all_valid", 1, 5, 'h00112);
        chk_balance("all_valid");

        // Sources 1 and 2 only, 2-beat fragments
        set_on(4'b0110); fixed_len = 2;
        do_reset();
        run(22);
        chk_ord("src12", 0, 6, 'h121212);
        chk_ord("src12", 1, 6, 'h112211);
        chk_balance("src12");

        // Source 3 alone, source 0 joins mid-fragment; pointer wraps to 0
        set_on(4'b1000); fixed_len = 4;
        do_reset();
        run(2);
        for (int i = 0; i < NI; i++) on[i][0] = 1'b1;
        run(16);
        chk_ord("wrap", 0, 2, 'h30);
        chk_ord("wrap", 1, 3, 'h330);
        chk_balance("wrap");

        // Granted source 0 stalls 5 cycles after its first beat, source 1 waits
        set_on(4'b0011); fixed_len = 4;
        do_reset();
        for (int i = 0; i < NI; i++) stall_req[i][0] = 1'b1;
        run(18);
        chk_ord("stall", 0, 2, 'h01);
        chk_ord("stall", 1, 2, 'h00);
        chk_balance("stall");

        // 16-beat fragment with random output backpressure
        set_on(4'b0100); fixed_len = 16; rdy_rand = 1'b1;
        do_reset();
        run(80);
        chk_ord("backpressure", 0, 1, 'h2);
        chk_ord("backpressure", 1, 1, 'h2);
        chk_balance("backpressure");
        for (int i = 0; i < NI; i++)
            chk($sformatf("backpressure_i%0d_min_beats", i), 64'(out_beats[i] >= 16), 64'd1);

        // Reset during the second beat of a fragment
        set_on(4'b1111); fixed_len = 4; rdy_rand = 1'b0;
        do_reset();
        run(2);
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("i%0d_midrst_grant", i), 64'(gnt[i]), 64'd0);
            chk($sformatf("i%0d_midrst_busy", i), 64'(busy[i]), 64'd0);
            chk($sformatf("i%0d_midrst_tvalid", i), 64'(o_vld[i]), 64'd0);
        end
        init_state();
        drive();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive();
        run(6);
        chk_ord("after_rst", 0, 1, 'h0);
        chk_ord("after_rst", 1, 1, 'h0);

        // Randomised traffic: varying lengths (incl. single beat), gaps, backpressure
        rand_mode = 1'b1; rdy_rand = 1'b1;
        set_on(4'b1111);
        do_reset();
        for (int r = 0; r < 15; r++) begin
            logic [N-1:0] m;
            m = N'($urandom);
            for (int i = 0; i < NI; i++)
                for (int k = 0; k < N; k++)
                    on[i][k] = m[k] || (beat_no[i][k] != 0);
            run(40);
        end
        chk_balance("random");
        for (int i = 0; i < NI; i++)
            chk($sformatf("random_i%0d_traffic", i), 64'(out_beats[i] > 0), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
